// File: rtl/slp_trainer.sv
// slp_trainer: drives a single-layer perceptron through a train-then-test run.
//
// A start pulse in IDLE launches EPOCH training epochs. Each epoch presents all
// 2^IN binary input patterns, one per cycle, with t_en high and the AND/OR
// target on train. A test pass follows. It re-presents every pattern with
// t_en low and holds each one for OLAT+1 cycles, then compares the perceptron
// output with the target and counts mismatches.
//
// Ports:
//   clk      - single rising-edge clock
//   reset    - synchronous, active-high reset (dominates start)
//   start    - begin a run; only sampled in IDLE
//   in       - IN packed lanes of I_PREC bits; lane i = in[i*I_PREC +: I_PREC]
//   train    - target code (CONST1/CONST0) zero-extended to O_PREC
//   rate     - learning rate, RATE while busy, else 0
//   t_en     - training enable, high only in TRAIN
//   out      - perceptron output, compared against train during TEST
//   busy     - high in TRAIN and TEST
//   done     - one-cycle pulse at the end of a run
//   err_cnt  - mismatches counted in the test pass (saturates at 2^IN)
//   pass     - err_cnt == 0, valid from done until the next start
module slp_trainer #(
  parameter int                IN     = 4,
  parameter int                I_PREC = 4,
  parameter int                O_PREC = 5,
  parameter int                R_PREC = 4,
  parameter logic [I_PREC-1:0] CONST1 = 4'b1_000,
  parameter logic [I_PREC-1:0] CONST0 = 4'b0_000,
  parameter logic [R_PREC-1:0] RATE   = 4'b0_001,
  parameter int                EPOCH  = 100,
  parameter int                FUNC   = 0,
  parameter int                OLAT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic [IN*I_PREC-1:0]   in,
  output logic [O_PREC-1:0]      train,
  output logic [R_PREC-1:0]      rate,
  output logic                   t_en,
  input  logic [O_PREC-1:0]      out,
  output logic                   busy,
  output logic                   done,
  output logic [IN:0]            err_cnt,
  output logic                   pass
);

  typedef enum logic [1:0] {IDLE, TRAIN, TEST, DONE} state_t;

  localparam logic [IN-1:0]     P_LAST     = '1;
  localparam logic [15:0]       EPOCH_LAST = 16'(EPOCH - 1);
  localparam logic [2:0]        HOLD_LAST  = 3'(OLAT);
  localparam logic [IN:0]       ERR_MAX    = {1'b1, {IN{1'b0}}};
  localparam logic [O_PREC-1:0] TGT1       = O_PREC'(CONST1);
  localparam logic [O_PREC-1:0] TGT0       = O_PREC'(CONST0);

  state_t       state, next_state;
  logic [IN-1:0] p;
  logic [15:0]   epoch;
  logic [2:0]    hold;
  logic          result_valid;
  logic          target;
  logic          last_train;
  logic          compare;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and output decode. Pattern lanes and target are only driven
  // while busy so the perceptron sees all-zero inputs in IDLE and DONE.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    t_en       = 1'b0;
    done       = 1'b0;
    in         = '0;
    train      = '0;
    target     = (FUNC == 0) ? (&p) : (|p);
    last_train = (p == P_LAST) && (epoch == EPOCH_LAST);
    compare    = (state == TEST) && (hold == HOLD_LAST);

    case (state)
      IDLE: begin
        if (start) next_state = TRAIN;
      end
      TRAIN: begin
        busy = 1'b1;
        t_en = 1'b1;
        if (last_train) next_state = TEST;
      end
      TEST: begin
        busy = 1'b1;
        if (compare && (p == P_LAST)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (busy) begin
      for (int i = 0; i < IN; i++) in[i*I_PREC +: I_PREC] = p[i] ? CONST1 : CONST0;
      train = target ? TGT1 : TGT0;
    end

    rate = busy ? RATE : '0;
    // The result is valid in DONE itself and then held through IDLE.
    pass = (done || result_valid) && (err_cnt == '0);
  end

  // Pattern, epoch and hold counters plus the mismatch tally.
  // The hold counter stretches each test pattern over OLAT+1 cycles so the
  // comparison lands on the cycle where the perceptron output has caught up.
  always_ff @(posedge clk) begin
    if (reset) begin
      p            <= '0;
      epoch        <= '0;
      hold         <= '0;
      err_cnt      <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            p            <= '0;
            epoch        <= '0;
            hold         <= '0;
            err_cnt      <= '0;
            result_valid <= 1'b0;
          end
        end
        TRAIN: begin
          p <= p + IN'(1);
          if (last_train) begin
            epoch <= '0;
            hold  <= '0;
          end else if (p == P_LAST) begin
            epoch <= epoch + 16'd1;
          end
        end
        TEST: begin
          if (compare) begin
            hold <= '0;
            p    <= p + IN'(1);
            if ((out != train) && (err_cnt != ERR_MAX)) err_cnt <= err_cnt + (IN+1)'(1);
          end else begin
            hold <= hold + 3'd1;
          end
        end
        DONE: begin
          p            <= '0;
          result_valid <= 1'b1;
        end
        default: p <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_slp_trainer.sv
// Testbench for slp_trainer. Two instances are used:
//   dut0: FUNC=0 (AND), EPOCH=2, OLAT=1
//   dut1: FUNC=1 (OR),  EPOCH=1, OLAT=3
// Each instance is paired with a behavioural perceptron whose output is the
// ideal target of the presented lanes, delayed by a selectable number of
// cycles, or tied to zero.
module tb_slp_trainer;

  logic        clk;
  logic        reset;
  logic        start0, start1;
  logic [15:0] in0, in1;
  logic [4:0]  train0, train1, out0, out1;
  logic [3:0]  rate0, rate1;
  logic        ten0, ten1, busy0, busy1, done0, done1, pass0, pass1;
  logic [4:0]  err0, err1;

  int mode0;
  int mode1;
  int cur;
  int checks;
  int errors;

  typedef struct {
    int busy;
    int tcyc;
    int err;
    bit pass;
  } exp_t;

  exp_t sbq[$];

  slp_trainer #(.FUNC(0), .EPOCH(2), .OLAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in(in0), .train(train0),
    .rate(rate0), .t_en(ten0), .out(out0), .busy(busy0), .done(done0),
    .err_cnt(err0), .pass(pass0)
  );

  slp_trainer #(.FUNC(1), .EPOCH(1), .OLAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in(in1), .train(train1),
    .rate(rate1), .t_en(ten1), .out(out1), .busy(busy1), .done(done1),
    .err_cnt(err1), .pass(pass1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural perceptron: ideal AND (dut0) / OR (dut1) of lanes equal to 1.0.
  logic [4:0] f0, f1;
  logic [4:0] h0 [0:7];
  logic [4:0] h1 [0:7];

  always_comb begin
    bit a;
    bit o;
    a = 1'b1;
    o = 1'b0;
    for (int i = 0; i < 4; i++) a = a & (in0[i*4 +: 4] == 4'b1000);
    for (int i = 0; i < 4; i++) o = o | (in1[i*4 +: 4] == 4'b1000);
    f0 = a ? 5'b01000 : 5'b00000;
    f1 = o ? 5'b01000 : 5'b00000;
  end

  always @(posedge clk) begin
    h0[0] <= f0;
    h1[0] <= f1;
    for (int i = 1; i < 8; i++) begin
      h0[i] <= h0[i-1];
      h1[i] <= h1[i-1];
    end
  end

  always_comb begin
    if (mode0 < 0)       out0 = 5'b00000;
    else if (mode0 == 0) out0 = f0;
    else                 out0 = h0[mode0-1];
    if (mode1 < 0)       out1 = 5'b00000;
    else if (mode1 == 0) out1 = f1;
    else                 out1 = h1[mode1-1];
  end

  // View of the instance currently under test.
  logic        s_busy, s_done, s_ten, s_pass;
  logic [4:0]  s_err, s_train;
  logic [15:0] s_in;
  logic [3:0]  s_rate;

  always_comb begin
    if (cur == 0) begin
      s_busy = busy0; s_done = done0; s_ten = ten0; s_pass = pass0;
      s_err = err0; s_train = train0; s_in = in0; s_rate = rate0;
    end else begin
      s_busy = busy1; s_done = done1; s_ten = ten1; s_pass = pass1;
      s_err = err1; s_train = train1; s_in = in1; s_rate = rate1;
    end
  end

  task automatic set_start(input logic v);
    if (cur == 0) start0 = v;
    else          start1 = v;
  endtask

  // Launch one run on the current instance and observe it until a few cycles
  // past done. Optionally pulses start mid-TRAIN and on the done cycle.
  task automatic do_run(input bit extra_starts, output int busy_n, output int tcyc_n,
                        output int done_n, output int err_v, output bit pass_v,
                        output int err_after, output bit pass_after,
                        output logic [29:0] quiet_after);
    int  post;
    bit  clr;
    busy_n = 0; tcyc_n = 0; done_n = 0; err_v = -1; pass_v = 1'b0;
    post = 4; clr = 1'b0;
    @(negedge clk);
    set_start(1'b1);
    for (int c = 0; c < 2000 && post > 0; c++) begin
      @(negedge clk);
      if (c == 0 || clr) set_start(1'b0);
      clr = 1'b0;
      if (s_busy) busy_n++;
      if (s_ten) tcyc_n++;
      if (extra_starts && (c == 5)) begin
        set_start(1'b1);
        clr = 1'b1;
      end
      if (s_done) begin
        done_n++;
        err_v  = int'(s_err);
        pass_v = s_pass;
        if (extra_starts) begin
          set_start(1'b1);
          clr = 1'b1;
        end
      end
      if (done_n > 0) post--;
    end
    set_start(1'b0);
    err_after   = int'(s_err);
    pass_after  = s_pass;
    quiet_after = {s_in, s_train, s_rate, s_busy, s_ten, s_done};
  endtask

  // Pop the expected record for the run just made and compare everything.
  task automatic run_and_score(input string name, input bit extra_starts);
    int busy_n, tcyc_n, done_n, err_v, err_after;
    bit pass_v, pass_after;
    logic [29:0] quiet;
    exp_t e;
    do_run(extra_starts, busy_n, tcyc_n, done_n, err_v, pass_v, err_after, pass_after, quiet);
    e = sbq.pop_front();
    checks++;
    if (done_n !== 1) begin
      errors++;
      $display("[TB] FAIL %s done_count got %0d want 1", name, done_n);
    end
    checks++;
    if (busy_n !== e.busy) begin
      errors++;
      $display("[TB] FAIL %s busy_len got %0d want %0d", name, busy_n, e.busy);
    end
    checks++;
    if (tcyc_n !== e.tcyc) begin
      errors++;
      $display("[TB] FAIL %s train_len got %0d want %0d", name, tcyc_n, e.tcyc);
    end
    checks++;
    if (err_v !== e.err || pass_v !== e.pass) begin
      errors++;
      $display("[TB] FAIL %s result err=%0d pass=%0b want err=%0d pass=%0b",
               name, err_v, pass_v, e.err, e.pass);
    end
    checks++;
    if (err_after !== e.err || pass_after !== e.pass || quiet !== 30'd0) begin
      errors++;
      $display("[TB] FAIL %s idle_hold err=%0d pass=%0b quiet=%h want err=%0d pass=%0b quiet=0",
               name, err_after, pass_after, quiet, e.err, e.pass);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({in0, train0, rate0, ten0, busy0, done0, err0, pass0} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut0 got %h want 0",
               {in0, train0, rate0, ten0, busy0, done0, err0, pass0});
    end
    checks++;
    if ({in1, train1, rate1, ten1, busy1, done1, err1, pass1} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_dut1 got %h want 0",
               {in1, train1, rate1, ten1, busy1, done1, err1, pass1});
    end
  endtask

  task automatic test_and_run();
    cur = 0; mode0 = 1;
    sbq.push_back('{busy: 64, tcyc: 32, err: 0, pass: 1'b1});
    run_and_score("and_ideal", 1'b0);
  endtask

  // Cycle-by-cycle check of the TRAIN phase lanes, target, rate and t_en.
  task automatic test_train_trace(input int sel, input int len);
    logic [15:0] exp_in;
    logic [4:0]  exp_tr;
    int          bad;
    int          p;
    cur = sel;
    if (sel == 0) mode0 = 1; else mode1 = 3;
    sbq.push_back('{busy: (sel == 0) ? 64 : 80, tcyc: len, err: 0, pass: 1'b1});
    @(negedge clk);
    set_start(1'b1);
    bad = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      set_start(1'b0);
      p = k % 16;
      for (int i = 0; i < 4; i++) exp_in[i*4 +: 4] = p[i] ? 4'b1000 : 4'b0000;
      if (sel == 0) exp_tr = (p == 15) ? 5'b01000 : 5'b00000;
      else          exp_tr = (p != 0)  ? 5'b01000 : 5'b00000;
      checks++;
      if (s_in !== exp_in || s_train !== exp_tr || s_ten !== 1'b1 || s_rate !== 4'b0001) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("[TB] FAIL trace%0d k=%0d in=%h train=%b t_en=%b rate=%b want in=%h train=%b t_en=1 rate=0001",
                   sel, k, s_in, s_train, s_ten, s_rate, exp_in, exp_tr);
      end
    end
    @(negedge clk);
    checks++;
    if (s_ten !== 1'b0 || s_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trace%0d test_entry t_en=%b busy=%b want t_en=0 busy=1", sel, s_ten, s_busy);
    end
    for (int c = 0; c < 200 && !s_done; c++) @(negedge clk);
    begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      if (s_done !== 1'b1 || int'(s_err) !== e.err || s_pass !== e.pass) begin
        errors++;
        $display("[TB] FAIL trace%0d end done=%b err=%0d pass=%b want done=1 err=%0d pass=%b",
                 sel, s_done, s_err, s_pass, e.err, e.pass);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_or_zero();
    cur = 1; mode1 = -1;
    sbq.push_back('{busy: 80, tcyc: 16, err: 15, pass: 1'b0});
    run_and_score("or_zero", 1'b0);
  endtask

  task automatic test_latency();
    cur = 1; mode1 = 3;
    sbq.push_back('{busy: 80, tcyc: 16, err: 0, pass: 1'b1});
    run_and_score("olat3_delay3", 1'b0);
    // A 3-cycle perceptron against OLAT=1 compares pattern 15 with the
    // response to pattern 14, which is the only AND disagreement.
    cur = 0; mode0 = 3;
    sbq.push_back('{busy: 64, tcyc: 32, err: 1, pass: 1'b0});
    run_and_score("olat1_delay3", 1'b0);
  endtask

  task automatic test_reset_mid();
    int dn, bn;
    cur = 0; mode0 = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    reset  = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
    start0 = 1'b0;
    checks++;
    if ({in0, train0, rate0, ten0, busy0, done0, err0, pass0} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid outputs got %h want 0",
               {in0, train0, rate0, ten0, busy0, done0, err0, pass0});
    end
    dn = 0; bn = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (done0) dn++;
      if (busy0) bn++;
    end
    checks++;
    if (dn !== 0 || bn !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid abort done=%0d busy=%0d want 0 0", dn, bn);
    end
    sbq.push_back('{busy: 64, tcyc: 32, err: 0, pass: 1'b1});
    run_and_score("after_reset", 1'b0);
  endtask

  task automatic test_start_ignored();
    cur = 0; mode0 = 1;
    sbq.push_back('{busy: 64, tcyc: 32, err: 0, pass: 1'b1});
    run_and_score("start_ignored", 1'b1);
  endtask

  // start held high across DONE restarts immediately after the IDLE cycle.
  task automatic test_back_to_back();
    int c;
    cur = 0; mode0 = 3;
    @(negedge clk);
    start0 = 1'b1;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done0 && c < 500);
    checks++;
    if (done0 !== 1'b1 || err0 !== 5'd1 || pass0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b first done=%b err=%0d pass=%b want 1 1 0", done0, err0, pass0);
    end
    @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || err0 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL b2b idle busy=%b err=%0d want 0 1", busy0, err0);
    end
    @(negedge clk);
    start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || ten0 !== 1'b1 || err0 !== 5'd0 || pass0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b restart busy=%b t_en=%b err=%0d pass=%b want 1 1 0 0",
               busy0, ten0, err0, pass0);
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done0 && c < 500);
    checks++;
    if (done0 !== 1'b1 || err0 !== 5'd1) begin
      errors++;
      $display("[TB] FAIL b2b second done=%b err=%0d want 1 1", done0, err0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    cur = 0; mode0 = 1; mode1 = 3;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
    test_reset();
    test_and_run();
    test_train_trace(0, 32);
    test_train_trace(1, 16);
    test_or_zero();
    test_latency();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    checks++;
    if (sbq.size() !== 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_left got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slp_trainer.md
SLP_TRAINER -- requirements
Module: slp_trainer

Interface
REQ-001 Parameter IN, 4: number of perceptron inputs; patterns enumerated 0..2^IN-1.
REQ-002 Parameter I_PREC, 4: bit width of each input lane.
REQ-003 Parameter O_PREC, 5: bit width of the train target and the perceptron out.
REQ-004 Parameter R_PREC, 4: bit width of the learning rate.
REQ-005 Parameter CONST1, 4'b1_000: input/target code for logic 1 (I_PREC bits).
REQ-006 Parameter CONST0, 4'b0_000: input/target code for logic 0 (I_PREC bits).
REQ-007 Parameter RATE, 4'b0_001: learning rate driven during training.
REQ-008 Parameter EPOCH, 100: number of training epochs, 1..65535.
REQ-009 Parameter FUNC, 0: target function; 0 = AND of all inputs, 1 = OR of all inputs.
REQ-010 Parameter OLAT, 1: perceptron in-to-out latency in cycles, 0..7.
REQ-011 clk  input  1  single clock; all state updates on rising edge.
REQ-012 reset  input  1  synchronous, active-high reset.
REQ-013 start  input  1  begin a train+test run; sampled only in IDLE.
REQ-014 in  output  IN x I_PREC  packed input lanes to perceptron.
REQ-015 train  output  O_PREC  training target to perceptron.
REQ-016 rate  output  R_PREC  learning rate to perceptron.
REQ-017 t_en  output  1  training-enable to perceptron.
REQ-018 out  input  O_PREC  perceptron output.
REQ-019 busy  output  1  high in TRAIN and TEST.
REQ-020 done  output  1  one-cycle pulse at end of run.
REQ-021 err_cnt  output  IN+1  mismatches counted in the test pass.
REQ-022 pass  output  1  err_cnt == 0, valid from done until next start.

Function
REQ-023 States SHALL be IDLE, TRAIN, TEST, DONE; IDLE->TRAIN on start; TRAIN->TEST after last pattern of epoch EPOCH; TEST->DONE after last pattern compared; DONE->IDLE unconditionally next cycle.
REQ-024 Pattern counter p (IN bits) SHALL drive in[i] = p[i] ? CONST1 : CONST0, zero elsewhere-free (no padding), lane i = bits [i*I_PREC +: I_PREC].
REQ-025 train SHALL equal target(p) ? CONST1 : CONST0, zero-extended to O_PREC; target = &p (FUNC=0) or |p (FUNC=1).
REQ-026 TRAIN SHALL present one pattern per cycle with t_en=1, p incrementing 0..2^IN-1, wrapping to 0 and incrementing the epoch counter; total TRAIN length exactly EPOCH*2^IN cycles.
REQ-027 rate SHALL equal RATE while busy, else 0.
REQ-028 TEST SHALL hold t_en=0 and each pattern for OLAT+1 cycles, comparing out to train on the last cycle; mismatch increments err_cnt (saturating at 2^IN); TEST length exactly 2^IN*(OLAT+1) cycles.
REQ-029 err_cnt SHALL clear on the start-accept cycle and hold its final value through DONE and IDLE.
REQ-030 start while busy or in DONE SHALL be ignored; start held high in IDLE after DONE SHALL begin a new run.
REQ-031 in and train SHALL be zero in IDLE and DONE.

Reset
REQ-032 reset SHALL dominate start and all state: next state IDLE; in, train, rate, t_en, busy, done, err_cnt, pass all 0; counters 0.
REQ-033 reset asserted mid-TRAIN or mid-TEST SHALL abort without a done pulse.

Verification
REQ-034 FUNC=0, EPOCH=2, OLAT=1, ideal AND model on out -> busy for 32+32 cycles, done one cycle, err_cnt=0, pass=1.
REQ-035 TRAIN trace, IN=4 -> cycle k in TRAIN shows in lanes from p=k mod 16, t_en=1, rate=4'b0001; train=5'b01000 only at p=15 (AND) / p!=0 (OR).
REQ-036 out tied to 5'b00000, FUNC=1 -> err_cnt=15, pass=0.
REQ-037 reset for one cycle at TRAIN cycle 10 -> all outputs 0 next cycle, no done; subsequent start gives full-length run.
REQ-038 start pulsed during TRAIN and on DONE cycle -> ignored; run length unchanged, single done.
REQ-039 OLAT=3, model out delayed 3 cycles -> err_cnt=0; same model with OLAT=0 -> err_cnt>0.
